// File: rtl/paj7620_pkg.sv
// Shared definitions for the PAJ7620 gesture sensor blocks: poll FSM encoding,
// gesture bit positions, register map constants and the direction decoder.
package paj7620_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_REQ  = 3'd2,
    ST_XFER = 3'd3,
    ST_EVAL = 3'd4
  } poll_state_e;

  localparam int GEST_UP    = 0;
  localparam int GEST_DOWN  = 1;
  localparam int GEST_LEFT  = 2;
  localparam int GEST_RIGHT = 3;

  localparam logic [7:0] PAJ_REG_GEST_FLAG = 8'h43;
  localparam logic [7:0] ERR_CNT_MAX       = 8'hFF;

  // Several flags can be set in one read; the highest direction bit wins.
  function automatic logic [3:0] gest_decode(input logic [3:0] nib);
    logic [3:0] oh;
    oh = '0;
    if (nib[GEST_RIGHT])     oh[GEST_RIGHT] = 1'b1;
    else if (nib[GEST_LEFT]) oh[GEST_LEFT]  = 1'b1;
    else if (nib[GEST_DOWN]) oh[GEST_DOWN]  = 1'b1;
    else if (nib[GEST_UP])   oh[GEST_UP]    = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/gesture_hold.sv
// Decodes a gesture flag nibble into a one-hot direction and holds it for
// HOLD_CNT cycles after the most recent detection.
module gesture_hold
  import paj7620_pkg::*;
#(
  parameter int HOLD_CNT = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       load,
  input  logic [3:0] nibble,
  output logic [3:0] gesture,
  output logic       gest_valid
);

  localparam int            HW        = $clog2(HOLD_CNT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);

  logic [3:0]    gesture_q, gesture_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          valid_q, valid_d;
  logic [3:0]    decoded;

  always_comb begin
    decoded    = gest_decode(nibble);
    gesture_d  = gesture_q;
    hold_cnt_d = hold_cnt_q;
    valid_d    = 1'b0;
    // A fresh detection (even a repeat) restarts the hold window and beats expiry.
    if (load && (decoded != 4'b0000)) begin
      gesture_d  = decoded;
      hold_cnt_d = '0;
      valid_d    = 1'b1;
    end else if (gesture_q != 4'b0000) begin
      if (hold_cnt_q == HOLD_LAST) begin
        gesture_d  = '0;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gesture_q  <= '0;
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      gesture_q  <= gesture_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign gesture    = gesture_q;
  assign gest_valid = valid_q;

endmodule

// File: rtl/gesture_poll_sched.sv
// Periodically polls the PAJ7620 gesture flag register through the shared I2C
// engine once configuration is done, and hands results to the hold/decode stage.
module gesture_poll_sched
  import paj7620_pkg::*;
#(
  parameter int         POLL_PERIOD = 1000,
  parameter int         HOLD_CNT    = 1000,
  parameter int         TIMEOUT     = 4095,
  parameter logic [7:0] GEST_REG    = PAJ_REG_GEST_FLAG
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cfg_done,
  output logic       i2c_req,
  output logic [7:0] i2c_reg,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_err,
  input  logic [7:0] i2c_rd_data,
  output logic [3:0] gesture,
  output logic       gest_valid,
  output logic [7:0] err_cnt
);

  localparam int            PW          = $clog2(POLL_PERIOD);
  localparam int            TW          = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

  poll_state_e   state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          req_q, req_d;
  logic [7:0]    err_q, err_d;
  logic [3:0]    rd_cap_q, rd_cap_d;
  logic          err_cap_q, err_cap_d;
  logic          err_inc;
  logic          hold_load;
  logic          unused_rd_hi;

  // The upper nibble of the flag register carries no direction information.
  assign unused_rd_hi = ^i2c_rd_data[7:4];

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    tmo_d     = tmo_q;
    req_d     = req_q;
    err_d     = err_q;
    rd_cap_d  = rd_cap_q;
    err_cap_d = err_cap_q;
    err_inc   = 1'b0;
    hold_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        if (cfg_done) begin
          state_d  = ST_WAIT;
          period_d = '0;
        end
      end

      ST_WAIT: begin
        if (!cfg_done) begin
          state_d = ST_IDLE;
        end else if (period_q == PERIOD_LAST) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          period_d = period_q + 1'b1;
        end
      end

      ST_REQ: begin
        // Once the engine has accepted, the transfer must be allowed to finish.
        if (i2c_busy) begin
          state_d = ST_XFER;
          req_d   = 1'b0;
          tmo_d   = tmo_q + 1'b1;
        end else if (!cfg_done) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end else if (tmo_q >= TMO_LAST) begin
          state_d  = ST_WAIT;
          period_d = '0;
          req_d    = 1'b0;
          err_inc  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_XFER: begin
        req_d = 1'b0;
        if (i2c_done) begin
          state_d   = ST_EVAL;
          rd_cap_d  = i2c_rd_data[3:0];
          err_cap_d = i2c_err;
        end else if (tmo_q >= TMO_LAST) begin
          state_d  = ST_WAIT;
          period_d = '0;
          err_inc  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_EVAL: begin
        if (err_cap_q) begin
          err_inc = 1'b1;
        end else begin
          hold_load = 1'b1;
        end
        if (cfg_done) begin
          state_d  = ST_WAIT;
          period_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (err_inc && (err_q != ERR_CNT_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      tmo_q     <= '0;
      req_q     <= 1'b0;
      err_q     <= '0;
      rd_cap_q  <= '0;
      err_cap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      tmo_q     <= tmo_d;
      req_q     <= req_d;
      err_q     <= err_d;
      rd_cap_q  <= rd_cap_d;
      err_cap_q <= err_cap_d;
    end
  end

  gesture_hold #(
    .HOLD_CNT (HOLD_CNT)
  ) u_hold (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load       (hold_load),
    .nibble     (rd_cap_q),
    .gesture    (gesture),
    .gest_valid (gest_valid)
  );

  assign i2c_req = req_q;
  assign i2c_reg = GEST_REG;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_gesture_poll_sched.sv
// Self-checking bench for gesture_poll_sched: engine model, table vectors,
// corner-case sequences and random polls against a timeline reference model.
module tb_gesture_poll_sched;

  localparam int P   = 20;
  localparam int H   = 100;
  localparam int TMO = 100;

  logic       sys_clk     = 1'b0;
  logic       sys_rst_n   = 1'b0;
  logic       cfg_done    = 1'b0;
  logic       i2c_busy    = 1'b0;
  logic       i2c_done    = 1'b0;
  logic       i2c_err     = 1'b0;
  logic [7:0] i2c_rd_data = 8'h00;
  logic       i2c_req;
  logic [7:0] i2c_reg;
  logic [3:0] gesture;
  logic       gest_valid;
  logic [7:0] err_cnt;

  gesture_poll_sched #(
    .POLL_PERIOD (P),
    .HOLD_CNT    (H),
    .TIMEOUT     (TMO),
    .GEST_REG    (8'h43)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cfg_done    (cfg_done),
    .i2c_req     (i2c_req),
    .i2c_reg     (i2c_reg),
    .i2c_busy    (i2c_busy),
    .i2c_done    (i2c_done),
    .i2c_err     (i2c_err),
    .i2c_rd_data (i2c_rd_data),
    .gesture     (gesture),
    .gest_valid  (gest_valid),
    .err_cnt     (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference timeline: latch events and error events scheduled at absolute cycles.
  logic [3:0] m_gest        = 4'b0000;
  int         m_latch       = 0;
  logic [3:0] pend_gest     = 4'b0000;
  int         pend_gest_cyc = -1;
  int         m_err         = 0;
  int         pend_err_cyc  = -1;
  int         next_req_cyc  = -1;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [3:0] exp_gest;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [3:0] ref_decode(input logic [7:0] d);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) r = 4'(4'b0001 << i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    bit lat;
    @(posedge sys_clk);
    #1;
    cyc++;
    lat = 1'b0;
    if (pend_gest_cyc == cyc) begin
      m_gest        = pend_gest;
      m_latch       = cyc;
      lat           = 1'b1;
      pend_gest_cyc = -1;
    end
    if (pend_err_cyc == cyc) begin
      if (m_err < 255) m_err++;
      pend_err_cyc = -1;
    end
    if (m_gest != 4'b0000 && (cyc - m_latch) >= H) m_gest = 4'b0000;
    chk("gesture", 32'(gesture), 32'(m_gest));
    chk("gest_valid", 32'(gest_valid), 32'(lat));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("i2c_reg", 32'(i2c_reg), 32'h43);
  endtask

  task automatic idle_ticks(input int n, input string name);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      if (i2c_req !== 1'b0) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  task automatic set_cfg();
    cfg_done     = 1'b1;
    next_req_cyc = cyc + 1 + P;
  endtask

  task automatic wait_req(output int r);
    int n;
    n = 0;
    while (i2c_req !== 1'b1 && n < 2 * P + TMO) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(i2c_req), 32'd1);
    chk("req_cycle", 32'(cyc), 32'(next_req_cyc));
    r = cyc;
  endtask

  task automatic do_poll(input logic [7:0] data, input logic err, input int b, input int x,
                         input bit no_resp, input bit drop_cfg, output logic v_at_latch);
    int r;
    int d;
    v_at_latch = 1'b0;
    wait_req(r);
    if (no_resp) begin
      pend_err_cyc = r + TMO;
      while (cyc < r + TMO - 1) tick();
      chk("req_held", 32'(i2c_req), 32'd1);
      tick();
      chk("req_tmo_drop", 32'(i2c_req), 32'd0);
      next_req_cyc = r + TMO + P;
    end else begin
      repeat (b) tick();
      i2c_busy = 1'b1;
      tick();
      chk("req_drop_accept", 32'(i2c_req), 32'd0);
      if (drop_cfg) cfg_done = 1'b0;
      repeat (x - 1) tick();
      i2c_busy    = 1'b0;
      i2c_done    = 1'b1;
      i2c_err     = err;
      i2c_rd_data = data;
      tick();
      d           = cyc;
      i2c_done    = 1'b0;
      i2c_err     = 1'b0;
      i2c_rd_data = 8'($urandom);
      if (err) begin
        pend_err_cyc = d + 1;
      end else if (ref_decode(data) != 4'b0000) begin
        pend_gest     = ref_decode(data);
        pend_gest_cyc = d + 1;
      end
      next_req_cyc = drop_cfg ? -1 : d + 1 + P;
      tick();
      v_at_latch = gest_valid;
      tick();
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    logic v;
    int   r;
    int   l1;
    int   l2;
    bit   seen;

    vecs[0]  = '{8'h04, 1'b0, 4'b0100};
    vecs[1]  = '{8'h0B, 1'b0, 4'b1000};
    vecs[2]  = '{8'h00, 1'b0, 4'b0000};
    vecs[3]  = '{8'h01, 1'b0, 4'b0001};
    vecs[4]  = '{8'h02, 1'b0, 4'b0010};
    vecs[5]  = '{8'h0F, 1'b0, 4'b1000};
    vecs[6]  = '{8'hF3, 1'b0, 4'b0010};
    vecs[7]  = '{8'hF0, 1'b0, 4'b0000};
    vecs[8]  = '{8'h06, 1'b0, 4'b0100};
    vecs[9]  = '{8'h08, 1'b1, 4'b0000};
    vecs[10] = '{8'h05, 1'b0, 4'b0100};
    vecs[11] = '{8'h80, 1'b0, 4'b0000};

    // Reset, then a long stretch with configuration incomplete.
    repeat (3) tick();
    chk("reset_req", 32'(i2c_req), 32'd0);
    sys_rst_n = 1'b1;
    idle_ticks(5000, "no_req_while_cfg_low");

    // Table vectors: busy two cycles after request, done twenty cycles later.
    set_cfg();
    for (int i = 0; i < 12; i++) begin
      do_poll(vecs[i].data, vecs[i].err, 2, 20, 1'b0, 1'b0, v);
      $display("[TB] poll data=%02h err=%0d gesture=%04b valid=%0d err_cnt=%0d",
               vecs[i].data, vecs[i].err, gesture, v, err_cnt);
      chk($sformatf("tbl%0d_valid", i), 32'(v), 32'(vecs[i].exp_gest != 4'b0000));
      if (vecs[i].exp_gest != 4'b0000)
        chk($sformatf("tbl%0d_gesture", i), 32'(gesture), 32'(vecs[i].exp_gest));
    end

    // Re-detection 90 cycles into the hold window, with cfg_done dropped mid-transfer.
    do_poll(8'h04, 1'b0, 2, 20, 1'b0, 1'b0, v);
    l1 = cyc - 1;
    do_poll(8'h04, 1'b0, 2, 66, 1'b0, 1'b1, v);
    l2 = cyc - 1;
    $display("[TB] redetect latch1=%0d latch2=%0d valid=%0d", l1, l2, v);
    chk("redetect_valid", 32'(v), 32'd1);
    seen = 1'b0;
    while (cyc < l1 + H) begin
      tick();
      if (i2c_req !== 1'b0) seen = 1'b1;
    end
    chk("held_past_first_window", 32'(gesture), 32'h4);
    while (cyc < l2 + H - 1) begin
      tick();
      if (i2c_req !== 1'b0) seen = 1'b1;
    end
    chk("held_to_end", 32'(gesture), 32'h4);
    tick();
    chk("hold_expired", 32'(gesture), 32'h0);
    chk("no_req_after_xfer_abort", 32'(seen), 32'd0);

    // cfg_done falls while the request is pending.
    set_cfg();
    wait_req(r);
    cfg_done = 1'b0;
    tick();
    $display("[TB] req abort at cycle %0d req=%0d", cyc, i2c_req);
    chk("req_abort_drop", 32'(i2c_req), 32'd0);
    idle_ticks(3 * P, "no_req_after_req_abort");

    // Engine never answers, then a NACK.
    set_cfg();
    do_poll(8'h00, 1'b0, 0, 0, 1'b1, 1'b0, v);
    $display("[TB] timeout poll err_cnt=%0d req=%0d", err_cnt, i2c_req);
    chk("tmo_err_cnt", 32'(err_cnt), 32'd2);
    do_poll(8'h08, 1'b1, 1, 5, 1'b0, 1'b0, v);
    $display("[TB] nack poll err_cnt=%0d gesture=%04b", err_cnt, gesture);
    chk("nack_err_cnt", 32'(err_cnt), 32'd3);
    chk("nack_no_update", 32'(gesture), 32'h0);

    // A stray done while waiting must be ignored.
    i2c_done    = 1'b1;
    i2c_err     = 1'b1;
    i2c_rd_data = 8'h01;
    tick();
    i2c_done = 1'b0;
    i2c_err  = 1'b0;
    do_poll(8'h02, 1'b0, 3, 4, 1'b0, 1'b0, v);
    $display("[TB] after stray done gesture=%04b err_cnt=%0d", gesture, err_cnt);
    chk("stray_done_err", 32'(err_cnt), 32'd3);
    chk("stray_done_gest", 32'(gesture), 32'h2);

    // Random polls against the timeline model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic       e;
      bit         nr;
      d  = 8'($urandom);
      e  = ($urandom_range(0, 7) == 0);
      nr = ($urandom_range(0, 9) == 0);
      do_poll(d, e, int'($urandom_range(0, 5)), int'($urandom_range(1, 40)), nr, 1'b0, v);
      $display("[TB] rand poll %0d data=%02h err=%0d noresp=%0d gesture=%04b err_cnt=%0d",
               i, d, e, nr, gesture, err_cnt);
    end

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      do_poll(8'h08, 1'b1, 0, 1, 1'b0, 1'b0, v);
    end
    $display("[TB] saturation err_cnt=%0d", err_cnt);
    chk("err_saturate", 32'(err_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gesture_poll_sched.md
Name: gesture_poll_sched

Overview:
- Controller that sequences the shared I2C engine to poll the PAJ7620 gesture-flag register periodically after the init configuration completes.
- Decodes each read result into a held one-hot direction vector for the beep and seg display consumers.
- Handles engine handshake, transfer timeout, NACK errors and abort when configuration drops.
- Sits between the cfg sequencer's done flag, the I2C engine's request port, and the display/beep logic.

Parameters:
- POLL_PERIOD, 1000: sys_clk cycles from end of one poll to the next request; minimum 2.
- HOLD_CNT, 1000: sys_clk cycles a decoded gesture stays asserted after its last detection; minimum 2.
- TIMEOUT, 4095: sys_clk cycles allowed from request entry to i2c_done before the poll is abandoned.
- GEST_REG, 8'h43: register address placed on i2c_reg for every poll.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  async active-low reset
- cfg_done  in  1  level; high while sensor init is complete
- i2c_req  out  1  read request to I2C engine
- i2c_reg  out  8  register address, constant GEST_REG while i2c_req high
- i2c_busy  in  1  engine busy; first high sample while i2c_req is high = accept
- i2c_done  in  1  one-cycle pulse, transfer finished
- i2c_err  in  1  qualified by i2c_done; NACK seen
- i2c_rd_data  in  8  read byte, valid with i2c_done
- gesture  out  4  one-hot held direction: [0] up, [1] down, [2] left, [3] right
- gest_valid  out  1  one-cycle pulse when a nonzero gesture is latched
- err_cnt  out  8  saturating count of NACKs plus timeouts

Behaviour:
- Reset (async) values:
  - i2c_req=0, i2c_reg=GEST_REG, gesture=0, gest_valid=0, err_cnt=0.
  - FSM=IDLE; period, timeout and hold counters=0.
- FSM states: IDLE, WAIT, REQ, XFER, EVAL.
  - IDLE: stays while cfg_done=0; cfg_done=1 -> WAIT with period counter cleared.
  - WAIT: period counter increments; at POLL_PERIOD-1 -> REQ. cfg_done=0 -> IDLE.
  - REQ: i2c_req=1 (registered). Timeout counter starts at 0 on entry. i2c_busy=1 -> XFER, and i2c_req drops in the same cycle XFER is entered. cfg_done=0 before accept -> IDLE, i2c_req deasserted.
  - XFER: i2c_req=0; timeout counter continues. i2c_done -> EVAL. Timeout counter reaching TIMEOUT-1 with no done -> err_cnt+1, then WAIT. cfg_done=0 is ignored here; the bus transfer is never aborted.
  - EVAL (single cycle): decode the captured byte.
    - If i2c_err was set with done: err_cnt+1, no gesture update.
    - Then -> WAIT if cfg_done=1, else IDLE.
- Timeout covers REQ and XFER combined; timeout in REQ behaves the same (err_cnt+1, -> WAIT, i2c_req dropped).
- i2c_done and timeout in the same cycle: done wins.
- i2c_done outside XFER is ignored.
- rd_data and err are captured on i2c_done into internal registers.
- Decode uses rd_data[3:0] only; bits [7:4] are ignored.
  - Priority: bit3 > bit2 > bit1 > bit0.
  - Result is the one-hot of the winning bit.
  - Nonzero result: gesture<=one-hot in the cycle after EVAL; gest_valid pulses that same cycle; hold counter restarts at 0. This applies to a repeat of the same gesture as well as a new one.
  - Zero result: no change; the hold timer keeps running.
- Hold timer:
  - While gesture!=0, the counter increments each cycle.
  - At HOLD_CNT-1: gesture<=0, counter<=0.
  - A new latch in the same cycle as expiry wins: new one-hot, counter 0.
- err_cnt saturates at 8'hFF.
- Latency: poll request to gesture output = engine transfer time + 2 cycles (EVAL + output register).

Decomposition:
- Shared package (paj7620_pkg):
  - FSM state encoding.
  - Gesture bit positions (UP=0, DOWN=1, LEFT=2, RIGHT=3).
  - PAJ7620 register constant 8'h43.
  - Shared by cfg and display blocks.
- One sub-module, gesture_hold: priority decode, one-hot register, hold counter and gest_valid.
  - Inputs: load strobe, nibble.
  - Parameter: HOLD_CNT.

Test Plan:
- Reset, cfg_done=0 for 5000 cycles -> i2c_req never asserts; all outputs at reset values.
- cfg_done=1, engine busy 2 cycles after req, done 20 cycles later with rd_data=8'h04 -> gesture=4'b0100 and gest_valid pulse exactly once, 2 cycles after done. Gesture clears HOLD_CNT cycles later.
- rd_data=8'h0B -> gesture=4'b1000 (bit3 priority). A following poll returns 8'h00 -> gesture stays until hold expiry.
- Same gesture re-detected at hold count 900 (HOLD_CNT=1000) -> counter restarts; gesture remains high 1000 cycles past the second latch.
- Engine never raises busy/done -> i2c_req drops at cycle TIMEOUT-1, err_cnt=1, next request POLL_PERIOD cycles later. Done with i2c_err=1 -> err_cnt+1, gesture unchanged. Force 300 errors -> err_cnt=255.
- cfg_done falls during XFER -> FSM waits for done, processes data, enters IDLE, no further i2c_req. cfg_done falls during REQ -> i2c_req drops next cycle.
